// File: rtl/fifo_rr_drain_pkg.sv
// Shared types and helpers for the round-robin FIFO drain scheduler.
// Holds the FSM encoding and the rotating channel-index helper.
package fifo_rr_drain_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Channel visited at step k of a search that starts just after 'last'.
  function automatic int next_ch(input int last, input int k, input int num_ch);
    return (last + k) % num_ch;
  endfunction

endpackage

// File: rtl/fifo_rr_drain_rr_pick.sv
// Rotating priority picker: first requester after 'last', wrapping modulo NumCh.
// Purely combinational so any arbiter can reuse it.
module rr_pick
  import fifo_rr_drain_pkg::*;
#(
  parameter int NumCh  = 4,
  parameter int ChBits = $clog2(NumCh)
) (
  input  logic [NumCh-1:0]  req,
  input  logic [ChBits-1:0] last,
  output logic              found,
  output logic [ChBits-1:0] idx
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    found = 1'b0;
    idx   = '0;
    // Walk farthest-first so the nearest requester after 'last' overwrites and wins.
    for (int k = NumCh; k >= 1; k--) begin
      if (req[next_ch(int'(last), k, NumCh)]) begin
        found = 1'b1;
        idx   = ChBits'(next_ch(int'(last), k, NumCh));
      end
    end
  end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NumCh upstream FIFOs into one tagged downstream FIFO.
// One grant at a time, bounded to BurstMax pops; output word is fully registered.
module fifo_rr_drain
  import fifo_rr_drain_pkg::*;
#(
  parameter int   Width    = 8,
  parameter int   NumCh    = 4,
  parameter int   BurstMax = 4,
  localparam int  ChBits   = $clog2(NumCh),
  localparam int  CntBits  = $clog2(BurstMax + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NumCh-1:0]        src_empty,
  output logic [NumCh-1:0]        src_rd_en,
  input  logic [NumCh*Width-1:0]  src_rd_data,
  input  logic                    dst_full,
  output logic                    dst_wr_en,
  output logic [ChBits+Width-1:0] dst_wr_data,
  output logic [ChBits-1:0]       grant_ch,
  output logic                    busy
);

  state_e                    state_q, state_d;
  logic [ChBits-1:0]         last_q, last_d;
  logic [ChBits-1:0]         grant_q, grant_d;
  logic [CntBits-1:0]        cnt_q, cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic [ChBits+Width-1:0]   out_data_q, out_data_d;
  logic                      pick_found;
  logic [ChBits-1:0]         pick_idx;
  logic                      pop;

  rr_pick #(
    .NumCh  (NumCh),
    .ChBits (ChBits)
  ) u_pick (
    .req   (~src_empty),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pop         = 1'b0;
    src_rd_en   = '0;
    dst_wr_en   = out_valid_q && !dst_full;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A full downstream only stalls; it never releases the grant.
        pop = !src_empty[grant_q] && (!out_valid_q || !dst_full);
        if (src_empty[grant_q]) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end else if (pop) begin
          cnt_d      = cnt_q + CntBits'(1);
          out_data_d = {grant_q, src_rd_data[int'(grant_q)*Width +: Width]};
          if (cnt_d == CntBits'(BurstMax)) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reload wins over drain so a simultaneous pop and write keep one word per cycle.
    if (pop) begin
      out_valid_d = 1'b1;
    end else if (dst_wr_en) begin
      out_valid_d = 1'b0;
    end

    src_rd_en[grant_q] = pop && !rst;
    busy               = (state_q == ST_GRANT) || out_valid_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= ChBits'(NumCh - 1);
      grant_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign dst_wr_data = out_data_q;
  assign grant_ch    = grant_q;

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Directed bench for fifo_rr_drain: queue-backed source FIFOs, per-cycle logs
// sampled on the falling edge, and hand-derived expected traces per scenario.
module tb_fifo_rr_drain;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int BURST  = 4;
  localparam int MAXC   = 64;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_CH-1:0]          src_empty;
  logic [NUM_CH-1:0]          src_rd_en;
  logic [NUM_CH*WIDTH-1:0]    src_rd_data;
  logic                       dst_full;
  logic                       dst_wr_en;
  logic [1+WIDTH:0]           dst_wr_data;
  logic [1:0]                 grant_ch;
  logic                       busy;

  int checks = 0;
  int errors = 0;
  int cyc;

  logic [WIDTH-1:0] src_q [NUM_CH][$];
  logic [3:0]       rd_log      [MAXC];
  logic             wr_en_log   [MAXC];
  logic [9:0]       wr_data_log [MAXC];
  logic             busy_log    [MAXC];
  logic [1:0]       grant_log   [MAXC];
  logic [9:0]       cap_data [$];
  int               cap_cyc  [$];

  always #5 clk = ~clk;

  fifo_rr_drain #(
    .Width    (WIDTH),
    .NumCh    (NUM_CH),
    .BurstMax (BURST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_empty   (src_empty),
    .src_rd_en   (src_rd_en),
    .src_rd_data (src_rd_data),
    .dst_full    (dst_full),
    .dst_wr_en   (dst_wr_en),
    .dst_wr_data (dst_wr_data),
    .grant_ch    (grant_ch),
    .busy        (busy)
  );

  task automatic drive_src();
    for (int i = 0; i < NUM_CH; i++) begin
      src_empty[i] = (src_q[i].size() == 0);
      src_rd_data[i*WIDTH +: WIDTH] = src_empty[i] ? '0 : src_q[i][0];
    end
  endtask

  task automatic load(input int ch, input logic [WIDTH-1:0] d);
    src_q[ch].push_back(d);
    drive_src();
  endtask

  // One clock: log outputs at the falling edge, then apply pops after the rising edge.
  task automatic tick();
    logic [NUM_CH-1:0] pops;
    @(negedge clk);
    if (cyc < MAXC) begin
      rd_log[cyc]      = src_rd_en;
      wr_en_log[cyc]   = dst_wr_en;
      wr_data_log[cyc] = dst_wr_data;
      busy_log[cyc]    = busy;
      grant_log[cyc]   = grant_ch;
    end
    if (dst_wr_en) begin
      cap_data.push_back(dst_wr_data);
      cap_cyc.push_back(cyc);
    end
    pops = src_rd_en;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pops[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive_src();
    cyc++;
  endtask

  task automatic start_test();
    cyc = 0;
    cap_data.delete();
    cap_cyc.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    dst_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) src_q[i].delete();
    drive_src();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    start_test();
    tick();
    checks++;
    if (rd_log[0] !== 4'b0000 || wr_en_log[0] !== 1'b0 || busy_log[0] !== 1'b0 ||
        grant_log[0] !== 2'd0 || wr_data_log[0] !== 10'h000) begin
      errors++;
      $display("FAIL reset_state rd=%b wr=%b busy=%b grant=%0d data=%h exp 0000/0/0/0/000",
               rd_log[0], wr_en_log[0], busy_log[0], grant_log[0], wr_data_log[0]);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_rd [7] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
    logic       exp_wr [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [9:0] exp_d  [3] = '{{2'd1, 8'hA1}, {2'd1, 8'hB2}, {2'd1, 8'hC3}};
    start_test();
    load(1, 8'hA1);
    load(1, 8'hB2);
    load(1, 8'hC3);
    repeat (7) tick();
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (rd_log[c] !== exp_rd[c] || wr_en_log[c] !== exp_wr[c]) begin
        errors++;
        $display("FAIL single_strobes cyc=%0d rd=%b wr=%b exp rd=%b wr=%b",
                 c, rd_log[c], wr_en_log[c], exp_rd[c], exp_wr[c]);
      end
    end
    checks++;
    if (cap_data.size() != 3) begin
      errors++;
      $display("FAIL single_count got=%0d exp=3", cap_data.size());
    end
    for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
      checks++;
      if (cap_data[i] !== exp_d[i] || cap_cyc[i] != 2 + i) begin
        errors++;
        $display("FAIL single_data idx=%0d got=%h@%0d exp=%h@%0d",
                 i, cap_data[i], cap_cyc[i], exp_d[i], 2 + i);
      end
    end
    checks++;
    if (grant_log[5] !== 2'd1 || busy_log[5] !== 1'b0) begin
      errors++;
      $display("FAIL single_end grant=%0d busy=%b exp grant=1 busy=0", grant_log[5], busy_log[5]);
    end
  endtask

  // After channel 1 released, the search starts at channel 2: ch3 beats ch0.
  task automatic test_last_priority();
    logic [9:0] exp_d [2] = '{{2'd3, 8'h30}, {2'd0, 8'h10}};
    int         exp_c [2] = '{2, 5};
    start_test();
    load(0, 8'h10);
    load(3, 8'h30);
    repeat (8) tick();
    checks++;
    if (cap_data.size() != 2) begin
      errors++;
      $display("FAIL last_count got=%0d exp=2", cap_data.size());
    end
    for (int i = 0; i < 2 && i < cap_data.size(); i++) begin
      checks++;
      if (cap_data[i] !== exp_d[i] || cap_cyc[i] != exp_c[i]) begin
        errors++;
        $display("FAIL last_order idx=%0d got=%h@%0d exp=%h@%0d",
                 i, cap_data[i], cap_cyc[i], exp_d[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [9:0] exp_d [2] = '{{2'd0, 8'h01}, {2'd3, 8'h03}};
    int         exp_c [2] = '{2, 5};
    do_reset();
    start_test();
    load(0, 8'h01);
    load(3, 8'h03);
    repeat (8) tick();
    checks++;
    if (cap_data.size() != 2) begin
      errors++;
      $display("FAIL wrap_count got=%0d exp=2", cap_data.size());
    end
    for (int i = 0; i < 2 && i < cap_data.size(); i++) begin
      checks++;
      if (cap_data[i] !== exp_d[i] || cap_cyc[i] != exp_c[i]) begin
        errors++;
        $display("FAIL wrap_order idx=%0d got=%h@%0d exp=%h@%0d",
                 i, cap_data[i], cap_cyc[i], exp_d[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    start_test();
    for (int k = 0; k < 8; k++) begin
      load(0, 8'(k));
      load(2, 8'(8'h20 + k));
    end
    repeat (24) tick();
    checks++;
    if (cap_data.size() != 16) begin
      errors++;
      $display("FAIL fair_count got=%0d exp=16", cap_data.size());
    end
    for (int k = 0; k < 16 && k < cap_data.size(); k++) begin
      int         burst;
      int         word;
      int         exp_c;
      logic [9:0] exp_d;
      burst = k / 4;
      word  = (burst / 2) * 4 + (k % 4);
      exp_d = (burst % 2 == 0) ? {2'd0, 8'(word)} : {2'd2, 8'(8'h20 + word)};
      exp_c = 2 + burst * 5 + (k % 4);
      checks++;
      if (cap_data[k] !== exp_d || cap_cyc[k] != exp_c) begin
        errors++;
        $display("FAIL fair_seq idx=%0d got=%h@%0d exp=%h@%0d",
                 k, cap_data[k], cap_cyc[k], exp_d, exp_c);
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_c [6] = '{2, 8, 9, 10, 12, 13};
    do_reset();
    start_test();
    for (int k = 0; k < 6; k++) load(3, 8'(8'h30 + k));
    for (int c = 0; c < 16; c++) begin
      dst_full = (c >= 3 && c <= 7);
      tick();
    end
    dst_full = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      checks++;
      if (rd_log[c] !== 4'b0000 || wr_en_log[c] !== 1'b0 || busy_log[c] !== 1'b1 ||
          grant_log[c] !== 2'd3 || wr_data_log[c] !== {2'd3, 8'h31}) begin
        errors++;
        $display("FAIL bp_stall cyc=%0d rd=%b wr=%b busy=%b grant=%0d data=%h exp 0000/0/1/3/331",
                 c, rd_log[c], wr_en_log[c], busy_log[c], grant_log[c], wr_data_log[c]);
      end
    end
    checks++;
    if (rd_log[10] !== 4'b0000 || rd_log[11] !== 4'b1000) begin
      errors++;
      $display("FAIL bp_regrant rd10=%b rd11=%b exp 0000/1000", rd_log[10], rd_log[11]);
    end
    checks++;
    if (cap_data.size() != 6) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=6", cap_data.size());
    end
    for (int i = 0; i < 6 && i < cap_data.size(); i++) begin
      checks++;
      if (cap_data[i] !== {2'd3, 8'(8'h30 + i)} || cap_cyc[i] != exp_c[i]) begin
        errors++;
        $display("FAIL bp_seq idx=%0d got=%h@%0d exp=%h@%0d",
                 i, cap_data[i], cap_cyc[i], {2'd3, 8'(8'h30 + i)}, exp_c[i]);
      end
    end
  endtask

  task automatic test_early_empty();
    logic [3:0] exp_rd [12] = '{4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h8,
                                4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    logic [9:0] exp_d  [4]  = '{{2'd2, 8'hA0}, {2'd2, 8'hA1}, {2'd3, 8'hB0}, {2'd0, 8'hC0}};
    int         exp_c  [4]  = '{2, 3, 6, 9};
    do_reset();
    start_test();
    load(2, 8'hA0);
    load(2, 8'hA1);
    for (int c = 0; c < 12; c++) begin
      if (c == 2) begin
        load(3, 8'hB0);
        load(0, 8'hC0);
      end
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (rd_log[c] !== exp_rd[c]) begin
        errors++;
        $display("FAIL early_rd cyc=%0d got=%b exp=%b", c, rd_log[c], exp_rd[c]);
      end
    end
    checks++;
    if (cap_data.size() != 4) begin
      errors++;
      $display("FAIL early_count got=%0d exp=4", cap_data.size());
    end
    for (int i = 0; i < 4 && i < cap_data.size(); i++) begin
      checks++;
      if (cap_data[i] !== exp_d[i] || cap_cyc[i] != exp_c[i]) begin
        errors++;
        $display("FAIL early_seq idx=%0d got=%h@%0d exp=%h@%0d",
                 i, cap_data[i], cap_cyc[i], exp_d[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic       exp_wr [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [9:0] exp_d  [6] = '{10'h000, 10'h000, {2'd0, 8'h52}, {2'd0, 8'h53},
                               {2'd0, 8'h54}, {2'd0, 8'h55}};
    do_reset();
    start_test();
    for (int k = 0; k < 6; k++) load(0, 8'(8'h50 + k));
    for (int c = 0; c < 10; c++) begin
      rst = (c == 3);
      tick();
    end
    rst = 1'b0;
    checks++;
    if (rd_log[3] !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_forced rd=%b exp=0000", rd_log[3]);
    end
    checks++;
    if (rd_log[4] !== 4'b0000 || wr_en_log[4] !== 1'b0 || busy_log[4] !== 1'b0 ||
        grant_log[4] !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_after rd=%b wr=%b busy=%b grant=%0d exp 0000/0/0/0",
               rd_log[4], wr_en_log[4], busy_log[4], grant_log[4]);
    end
    checks++;
    if (rd_log[5] !== 4'b0001 || grant_log[5] !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_regrant rd=%b grant=%0d exp 0001/0", rd_log[5], grant_log[5]);
    end
    for (int c = 4; c < 10; c++) begin
      checks++;
      if (wr_en_log[c] !== exp_wr[c-4] || (exp_wr[c-4] && wr_data_log[c] !== exp_d[c-4])) begin
        errors++;
        $display("FAIL rstmid_stream cyc=%0d wr=%b data=%h exp wr=%b data=%h",
                 c, wr_en_log[c], wr_data_log[c], exp_wr[c-4], exp_d[c-4]);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    dst_full    = 1'b0;
    src_empty   = '1;
    src_rd_data = '0;
    cyc         = 0;
    test_reset();
    test_single();
    test_last_priority();
    test_wrap();
    test_fairness();
    test_backpressure();
    test_early_empty();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout sim_time=%0t limit=200000", $time);
    $fatal(1, "bench time limit expired");
  end

endmodule
